mmio_responder: RTL and testbench

- Memory-mapped responder on the ktc16 data bus; the target end of the CPU's addr/wd/memwrite/rd interface.
- Decodes a 4-word window and provides:
  - a TX mailbox: a FIFO drained over a valid/ready stream;
  - a RESULT register that latches the program's final answer and flags pass/fail;
  - a status word;
  - a free-running cycle counter.
- Sits beside the ram; the top level muxes rd from ram or responder on the window hit.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/mmio_responder.sv | 114 +++++++++++
 tb/tb_mmio_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared register-map constants and the STATUS word layout for the ktc16 MMIO responder.
// Used by mmio_responder; see that file for the MMIO_CYCLE_COUNTER_EN build option.
package mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RESULT = 2'd2;
  localparam logic [1:0] OFF_CYCLE  = 2'd3;

  localparam int unsigned ST_DONE      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_FULL      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef struct packed {
    logic [7:0] count;
    logic [3:0] rsvd;
    logic       overflow;
    logic       full;
    logic       empty;
    logic       done;
  } status_t;

  function automatic logic [1:0] reg_offset(input logic [15:0] a);
    return a[1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head (no fall-through), sticky overflow on a dropped push.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign overflow = ovf_q;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = AW'(wptr_q + 1'b1);
    if (pop_ok)  rptr_d = AW'(rptr_q + 1'b1);
    if (push_ok && !pop_ok) count_d = CW'(count_q + 1'b1);
    if (pop_ok && !push_ok) count_d = CW'(count_q - 1'b1);
    if (push && !push_ok)   ovf_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

  // Storage is not reset; gating keeps the head at zero whenever nothing is queued.
  assign rdata = empty ? '0 : mem[rptr_q];

endmodule

// File: rtl/mmio_responder.sv
// ktc16 MMIO responder: 4-word window with TX mailbox FIFO, RESULT/pass latch, STATUS and CYCLE.
// Define MMIO_CYCLE_COUNTER_EN to build the CYCLE counter; otherwise offset 3 reads zero.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE   = 16'h0050,
  parameter int unsigned DEPTH  = 8,
  parameter logic [15:0] EXPECT = 16'd144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wd,
  input  logic        memwrite,
  output logic        sel,
  output logic [15:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic        pass
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]    off;
  logic          wr;
  logic          push, pop;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [15:0]   result_q;
  logic          done_q, pass_q;
  status_t       status;
  logic [15:0]   cycle_val;

  assign sel = (addr[15:2] == BASE[15:2]);
  assign off = reg_offset(addr);
  assign wr  = memwrite && sel;

  assign push     = wr && (off == OFF_TXDATA);
  assign tx_valid = !fifo_empty;
  assign pop      = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wdata    (wd[7:0]),
    .pop      (pop),
    .rdata    (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  // First RESULT write wins; pass is captured alongside it so both flags rise together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else if (wr && (off == OFF_RESULT) && !done_q) begin
      result_q <= wd;
      done_q   <= 1'b1;
      pass_q   <= (wd == EXPECT);
    end
  end

  assign done = done_q;
  assign pass = pass_q;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [15:0] cycle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = 16'h0000;
`endif

  always_comb begin
    status          = '0;
    status.count    = 8'(fifo_count);
    status.overflow = fifo_ovf;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.done     = done_q;
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      unique case (off)
        OFF_TXDATA: rd = '0;
        OFF_STATUS: rd = status;
        OFF_RESULT: rd = result_q;
        OFF_CYCLE:  rd = cycle_val;
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboarded bench for mmio_responder: queue-based FIFO model, negedge stream monitor.
// Build with MMIO_CYCLE_COUNTER_EN to also exercise the CYCLE counter and its wrap.
module tb_mmio_responder;

  localparam logic [15:0] BASE   = 16'h0050;
  localparam int          DEPTH  = 8;
  localparam logic [15:0] EXPECT = 16'd144;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wd = '0;
  logic        memwrite = 1'b0;
  logic        tx_ready = 1'b0;
  logic        sel;
  logic [15:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        done;
  logic        pass;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb_q[$];
  int          m_cnt;
  bit          m_ovf;
  bit          m_done;
  logic [15:0] m_result;
  logic [15:0] m_cycle;

  mmio_responder #(
    .BASE   (BASE),
    .DEPTH  (DEPTH),
    .EXPECT (EXPECT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wd       (wd),
    .memwrite (memwrite),
    .sel      (sel),
    .rd       (rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done),
    .pass     (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor: every accepted byte must match the oldest byte the model accepted.
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_unexpected actual=%h required=none at %0t", tx_data, $time);
      end else begin
        chk("stream_data", {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (a[15:2] != BASE[15:2]) return 16'h0000;
    case (a[1:0])
      2'd1: return {8'(m_cnt), 4'b0000, m_ovf, (m_cnt == DEPTH), (m_cnt == 0), m_done};
      2'd2: return m_result;
`ifdef MMIO_CYCLE_COUNTER_EN
      2'd3: return m_cycle;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we,
                      input logic rdy);
    logic [15:0] exp_rd;
    logic        exp_valid, exp_done, exp_pass, exp_sel, do_pop;
    logic [7:0]  exp_head;
    addr     = a;
    wd       = d;
    memwrite = we;
    tx_ready = rdy;
    exp_rd    = model_rd(a);
    exp_sel   = (a[15:2] == BASE[15:2]);
    exp_valid = (m_cnt > 0);
    exp_head  = (m_cnt > 0) ? sb_q[0] : 8'h00;
    exp_done  = m_done;
    exp_pass  = m_done && (m_result == EXPECT);
    do_pop    = (m_cnt > 0) && rdy;
    if (we && exp_sel && a[1:0] == 2'd0) begin
      if (m_cnt < DEPTH || do_pop) begin
        sb_q.push_back(d[7:0]);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (do_pop) m_cnt--;
    if (we && exp_sel && a[1:0] == 2'd2 && !m_done) begin
      m_done   = 1'b1;
      m_result = d;
    end
    @(negedge clk);
    chk("rd", {16'd0, rd}, {16'd0, exp_rd});
    chk("sel", {31'd0, sel}, {31'd0, exp_sel});
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, exp_valid});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("pass", {31'd0, pass}, {31'd0, exp_pass});
    if (exp_valid) chk("tx_head", {24'd0, tx_data}, {24'd0, exp_head});
    @(posedge clk);
    m_cycle = m_cycle + 16'd1;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    addr     = BASE + 16'd1;
    memwrite = 1'b0;
    reset    = 1'b0;
    #2;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_status", {16'd0, rd}, 32'h0002);
    sb_q.delete();
    m_cnt    = 0;
    m_ovf    = 1'b0;
    m_done   = 1'b0;
    m_result = '0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_cycle = '0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(BASE + 16'(i % 4), 16'h0, 1'b0, rdy);
  endtask

  initial begin
    do_reset();

    // Reset-state reads of all four offsets.
    for (int i = 0; i < 4; i++) step(BASE + 16'(i), 16'h0, 1'b0, 1'b0);

    // Two bytes queued, then drained back to back.
    step(BASE, 16'h0041, 1'b1, 1'b0);
    step(BASE, 16'h0042, 1'b1, 1'b0);
    step(BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Overflow: ninth push with no pop is dropped.
    for (int i = 0; i < DEPTH; i++) step(BASE, 16'(8'h60 + i), 1'b1, 1'b0);
    step(BASE, 16'h00EE, 1'b1, 1'b0);
    step(BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b1);
    step(BASE + 16'd1, 16'h0, 1'b0, 1'b0);

    // Full with simultaneous pop: both happen, no overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(BASE, 16'(8'h70 + i), 1'b1, 1'b0);
    step(BASE, 16'h00DD, 1'b1, 1'b1);
    step(BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // RESULT: matching value, then ignored second write.
    step(BASE + 16'd2, 16'd144, 1'b1, 1'b0);
    step(BASE + 16'd2, 16'd7, 1'b1, 1'b0);
    step(BASE + 16'd2, 16'h0, 1'b0, 1'b0);
    step(BASE + 16'd1, 16'h0, 1'b0, 1'b0);

    // RESULT mismatch, out-of-window writes, ram address 80 claimed.
    do_reset();
    step(BASE + 16'd2, 16'd143, 1'b1, 1'b0);
    step(BASE + 16'd2, 16'h0, 1'b0, 1'b0);
    step(BASE + 16'd4, 16'h0055, 1'b1, 1'b0);
    step(BASE + 16'd6, 16'd144, 1'b1, 1'b0);
    step(16'd80, 16'h0, 1'b0, 1'b0);
    step(BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    step(BASE + 16'd3, 16'h1234, 1'b1, 1'b0);
    step(BASE + 16'd1, 16'hFFFF, 1'b1, 1'b0);
    step(BASE + 16'd3, 16'h0, 1'b0, 1'b0);

    // Randomized traffic, with a mid-stream reset partway through.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 9) < 8) a = BASE + 16'($urandom_range(0, 3));
      else a = 16'($urandom);
      if (i == 400) begin
        for (int k = 0; k < 3; k++) step(BASE, 16'($urandom), 1'b1, 1'b0);
        do_reset();
      end
      step(a, 16'($urandom), 1'($urandom), 1'($urandom));
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    // Let the counter run past 16'hFFFF; every step compares CYCLE against the model.
    do_reset();
    for (int i = 0; i < 65540; i++) step(BASE + 16'd3, 16'h0, 1'b0, 1'b0);
`endif

    idle(DEPTH + 2, 1'b1);
    chk("drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
